instr_decode: RTL and testbench
===============================

Name: instr_decode

Overview:
RV32I decode stage sitting directly upstream of reg32Blk. Accepts one instruction from fetch over a valid/ready handshake and decodes its fields. It then drives rs1/rs2/regLd into the register file and waits for outputValid. It issues decoded operands, immediate and ALU op to execute over a second valid/ready handshake. Single instruction in flight; integer ALU classes only (OP, OP-IMM, LUI, AUIPC); all other opcodes are flagged illegal.

Parameters:
D_WIDTH, 32, datapath/register width
REG_AW, 5, register index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
instrValid  in  1  fetch has an instruction
instrReady  out  1  decode can accept
instr  in  32  instruction word
instrPc  in  D_WIDTH  PC of instr
rs1  out  REG_AW  register file read index 1
rs2  out  REG_AW  register file read index 2
regLd  out  1  register file read request
regOutputValid  in  1  reg32Blk outputValid
rs1Dat  in  D_WIDTH  reg32Blk rs1Out
rs2Dat  in  D_WIDTH  reg32Blk rs2Out
exValid  out  1  decoded bundle valid
exReady  in  1  execute accepts bundle
exOp  out  4  alu_op_t
exUseImm  out  1  operand B = exImm
exImm  out  D_WIDTH  sign-extended immediate
exRs1Val  out  D_WIDTH  operand A value (AUIPC: instrPc)
exRs2Val  out  D_WIDTH  operand B register value
exRd  out  REG_AW  destination index
exRdWr  out  1  write-back enable (0 when rd==0)
exPc  out  D_WIDTH  instrPc of bundle
illegal  out  1  one-cycle pulse, unsupported opcode/funct

Behaviour:
- FSM states: IDLE, REGRD, ISSUE. Reset → IDLE. Every output resets to 0 except instrReady, which is 1 in IDLE.
- IDLE: instrReady=1. On instrValid&&instrReady at edge N, all fields are decoded and registered at that edge.
  - OP / OP-IMM → REGRD.
  - LUI / AUIPC → ISSUE directly, with no register read.
  - Illegal → illegal=1 during cycle N+1; stay IDLE; no exValid.
- REGRD: regLd=1, with rs1 and rs2 held stable. rs2 is forced to 0 for OP-IMM. Stay until regOutputValid=1 is sampled. At that edge, capture rs1Dat→exRs1Val and rs2Dat→exRs2Val, then go to ISSUE. regLd drops the cycle after capture.
- ISSUE: exValid=1. All ex* outputs are held constant while exReady=0. On exValid&&exReady → IDLE; exValid=0 the next cycle.
- instrReady=0 outside IDLE. Minimum cycles between accepts: 2 for LUI, 3+ for OP.
- Decode rules:
  - OP: funct7 0x00 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3. funct7 0x20 with funct3 0 → SUB; funct7 0x20 with funct3 5 → SRA. Any other funct7 → illegal.
  - OP-IMM: I-imm is sign-extended. SLLI/SRLI/SRAI use imm[4:0] as shamt, and imm[11:5] must be 0x00 (0x20 for SRAI), else illegal.
  - LUI: exOp=PASSB, exImm={instr[31:12],12'b0}, exRs1Val=0.
  - AUIPC: exOp=ADD, exRs1Val=instrPc, exImm=U-imm.
- exRdWr = (rd != 0) for all legal classes.
- Arithmetic: no arithmetic in this block beyond sign extension. All immediates are D_WIDTH wide.
- rst asserted in any state: the next cycle is IDLE and all outputs are at their reset values. An in-flight instruction is discarded and never re-issued.
- regOutputValid outside REGRD is ignored.

Decomposition:
- Package decode_pkg:
  - alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB)
  - opcode constants (OPC_OP=7'b0110011, OPC_OPIMM=7'b0010011, OPC_LUI=7'b0110111, OPC_AUIPC=7'b0010111)
  - dec_state_t
- One sub-module, imm_gen: a combinational I/U immediate builder from instr and class.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1Dat=5, rs2Dat=7, outputValid 2 cycles after regLd → rs1=1, rs2=2, regLd held 2 cycles; bundle exOp=ADD, exRs1Val=5, exRs2Val=7, exUseImm=0, exRd=3, exRdWr=1.
- sub x2,x1,x2 (0x40208133) and srai x4,x4,3 (0x40325213) → exOp=SUB; then exOp=SRA, exImm[4:0]=3, rs2=0, exUseImm=1.
- addi x0,x0,-1 (0xFFF00013) → exImm=0xFFFFFFFF, exRd=0, exRdWr=0.
- lui x1,0x12345 (0x123450B7) → regLd never asserted; exValid cycle after accept; exImm=0x12345000, exOp=PASSB.
- exReady low for 3 cycles in ISSUE → exValid and all ex* stable, instrReady=0; accepted on cycle 4. Separately, instr=0x00000000 → illegal pulse of 1 cycle, exValid stays 0, instrReady=1 the following cycle.
- rst asserted for 1 cycle during REGRD → next cycle regLd=0, exValid=0, instrReady=1; a later outputValid pulse produces no issue.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I integer decode stage.
// Holds the ALU op encoding, major opcode values and decode FSM states.
package decode_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        SLL   = 4'd2,
        SLT   = 4'd3,
        SLTU  = 4'd4,
        XOR   = 4'd5,
        SRL   = 4'd6,
        SRA   = 4'd7,
        OR    = 4'd8,
        AND   = 4'd9,
        PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REGRD = 2'd1,
        ISSUE = 2'd2
    } dec_state_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // funct3 -> op for the funct7==0 encodings shared by OP and OP-IMM.
    function automatic alu_op_t base_op(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            3'd0:    op = ADD;
            3'd1:    op = SLL;
            3'd2:    op = SLT;
            3'd3:    op = SLTU;
            3'd4:    op = XOR;
            3'd5:    op = SRL;
            3'd6:    op = OR;
            default: op = AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate builder: sign-extended I-immediate or U-immediate.
// Only instr[31:12] carries immediate bits for these two formats.
module imm_gen #(
    parameter int D_WIDTH = 32
) (
    input  logic [19:0]        instr_hi_i,
    input  logic               u_type_i,
    output logic [D_WIDTH-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        if (u_type_i) begin
            imm32 = {instr_hi_i, 12'b0};
        end else begin
            imm32 = {{20{instr_hi_i[19]}}, instr_hi_i[19:8]};
        end
    end

    assign imm_o = D_WIDTH'($signed(imm32));

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage for OP/OP-IMM/LUI/AUIPC: fetch handshake in, register
// file read, then one decoded bundle out to execute. One instruction in flight.
module instr_decode
    import decode_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int REG_AW  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instrValid,
    output logic               instrReady,
    input  logic [31:0]        instr,
    input  logic [D_WIDTH-1:0] instrPc,
    output logic [REG_AW-1:0]  rs1,
    output logic [REG_AW-1:0]  rs2,
    output logic               regLd,
    input  logic               regOutputValid,
    input  logic [D_WIDTH-1:0] rs1Dat,
    input  logic [D_WIDTH-1:0] rs2Dat,
    output logic               exValid,
    input  logic               exReady,
    output logic [3:0]         exOp,
    output logic               exUseImm,
    output logic [D_WIDTH-1:0] exImm,
    output logic [D_WIDTH-1:0] exRs1Val,
    output logic [D_WIDTH-1:0] exRs2Val,
    output logic [REG_AW-1:0]  exRd,
    output logic               exRdWr,
    output logic [D_WIDTH-1:0] exPc,
    output logic               illegal,
    output logic [1:0]         dbgState
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Once exValid rises, every ex* output holds until exReady is seen.

    dec_state_t state_q, state_d;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    alu_op_t dec_op;
    logic    dec_legal;
    logic    dec_use_imm;
    logic    dec_rd_regs;
    logic    dec_u_type;
    logic    dec_zero_rs2;

    always_comb begin
        dec_op       = ADD;
        dec_legal    = 1'b0;
        dec_use_imm  = 1'b0;
        dec_rd_regs  = 1'b0;
        dec_u_type   = 1'b0;
        dec_zero_rs2 = 1'b0;
        case (opc)
            OPC_OP: begin
                dec_rd_regs = 1'b1;
                if (f7 == 7'h00) begin
                    dec_legal = 1'b1;
                    dec_op    = base_op(f3);
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    dec_legal = 1'b1;
                    dec_op    = SUB;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    dec_legal = 1'b1;
                    dec_op    = SRA;
                end
            end
            OPC_OPIMM: begin
                dec_rd_regs  = 1'b1;
                dec_use_imm  = 1'b1;
                dec_zero_rs2 = 1'b1;
                dec_op       = base_op(f3);
                // Shift-immediates reuse imm[11:5] as a funct7 qualifier.
                case (f3)
                    3'd1:    dec_legal = (f7 == 7'h00);
                    3'd5: begin
                        dec_legal = (f7 == 7'h00) || (f7 == 7'h20);
                        if (f7 == 7'h20) dec_op = SRA;
                    end
                    default: dec_legal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_legal   = 1'b1;
                dec_op      = PASSB;
                dec_use_imm = 1'b1;
                dec_u_type  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_legal   = 1'b1;
                dec_op      = ADD;
                dec_use_imm = 1'b1;
                dec_u_type  = 1'b1;
            end
            default: ;
        endcase
    end

    logic [D_WIDTH-1:0] dec_imm;

    imm_gen #(
        .D_WIDTH(D_WIDTH)
    ) u_imm_gen (
        .instr_hi_i(instr[31:12]),
        .u_type_i  (dec_u_type),
        .imm_o     (dec_imm)
    );

    always_comb begin
        state_d    = state_q;
        instrReady = 1'b0;
        regLd      = 1'b0;
        exValid    = 1'b0;
        case (state_q)
            IDLE: begin
                instrReady = 1'b1;
                if (instrValid && dec_legal) state_d = dec_rd_regs ? REGRD : ISSUE;
            end
            REGRD: begin
                regLd = 1'b1;
                if (regOutputValid) state_d = ISSUE;
            end
            ISSUE: begin
                exValid = 1'b1;
                if (exReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    logic [REG_AW-1:0]  rs1_q, rs2_q, ex_rd_q;
    alu_op_t            ex_op_q;
    logic               ex_use_imm_q, ex_rd_wr_q, illegal_q;
    logic [D_WIDTH-1:0] ex_imm_q, ex_rs1_q, ex_rs2_q, ex_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q        <= '0;
            rs2_q        <= '0;
            ex_op_q      <= ADD;
            ex_use_imm_q <= 1'b0;
            ex_imm_q     <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
            ex_rd_wr_q   <= 1'b0;
            ex_pc_q      <= '0;
            illegal_q    <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instrValid && !dec_legal) begin
                        illegal_q <= 1'b1;
                    end else if (instrValid) begin
                        rs1_q        <= dec_u_type ? '0 : REG_AW'(instr[19:15]);
                        rs2_q        <= (dec_u_type || dec_zero_rs2) ? '0 : REG_AW'(instr[24:20]);
                        ex_op_q      <= dec_op;
                        ex_use_imm_q <= dec_use_imm;
                        // Register-register ops carry a zero immediate.
                        ex_imm_q     <= dec_use_imm ? dec_imm : '0;
                        ex_rs1_q     <= (opc == OPC_AUIPC) ? instrPc : '0;
                        ex_rs2_q     <= '0;
                        ex_rd_q      <= REG_AW'(instr[11:7]);
                        ex_rd_wr_q   <= (instr[11:7] != 5'd0);
                        ex_pc_q      <= instrPc;
                    end
                end
                REGRD: begin
                    if (regOutputValid) begin
                        ex_rs1_q <= rs1Dat;
                        ex_rs2_q <= rs2Dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rs1      = rs1_q;
    assign rs2      = rs2_q;
    assign exOp     = ex_op_q;
    assign exUseImm = ex_use_imm_q;
    assign exImm    = ex_imm_q;
    assign exRs1Val = ex_rs1_q;
    assign exRs2Val = ex_rs2_q;
    assign exRd     = ex_rd_q;
    assign exRdWr   = ex_rd_wr_q;
    assign exPc     = ex_pc_q;
    assign illegal  = illegal_q;
    assign dbgState = state_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed scenarios plus a random
// back-to-back run, with issued bundles checked against an expected queue.
module tb_instr_decode;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instrValid = 1'b0;
    logic        instrReady;
    logic [31:0] instr = '0;
    logic [31:0] instrPc = '0;
    logic [4:0]  rs1, rs2;
    logic        regLd;
    logic        regOutputValid = 1'b0;
    logic [31:0] rs1Dat = '0, rs2Dat = '0;
    logic        exValid;
    logic        exReady = 1'b1;
    logic [3:0]  exOp;
    logic        exUseImm;
    logic [31:0] exImm, exRs1Val, exRs2Val, exPc;
    logic [4:0]  exRd;
    logic        exRdWr;
    logic        illegal;
    logic [1:0]  dbgState;

    instr_decode dut (
        .clk(clk), .rst(rst),
        .instrValid(instrValid), .instrReady(instrReady), .instr(instr), .instrPc(instrPc),
        .rs1(rs1), .rs2(rs2), .regLd(regLd),
        .regOutputValid(regOutputValid), .rs1Dat(rs1Dat), .rs2Dat(rs2Dat),
        .exValid(exValid), .exReady(exReady), .exOp(exOp), .exUseImm(exUseImm),
        .exImm(exImm), .exRs1Val(exRs1Val), .exRs2Val(exRs2Val),
        .exRd(exRd), .exRdWr(exRdWr), .exPc(exPc),
        .illegal(illegal), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic        use_imm;
        logic [31:0] imm;
        logic [31:0] r1v;
        logic [31:0] r2v;
        logic [4:0]  rd;
        logic        rd_wr;
        logic [31:0] pc;
    } bundle_t;

    localparam int BW = $bits(bundle_t);

    logic [BW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   regs[32];

    function automatic bundle_t mk(input alu_op_t op, input logic ui, input logic [31:0] imm,
                                   input logic [31:0] r1v, input logic [31:0] r2v,
                                   input logic [4:0] rd, input logic [31:0] pc);
        bundle_t b;
        b.op = op; b.use_imm = ui; b.imm = imm; b.r1v = r1v; b.r2v = r2v;
        b.rd = rd; b.rd_wr = (rd != 5'd0); b.pc = pc;
        return b;
    endfunction

    function automatic alu_op_t ref_op(input logic [2:0] f3);
        case (f3)
            3'd0: return ADD;
            3'd1: return SLL;
            3'd2: return SLT;
            3'd3: return SLTU;
            3'd4: return XOR;
            3'd5: return SRL;
            3'd6: return OR;
            default: return AND;
        endcase
    endfunction

    // Scoreboard: every completed execute handshake pops one expected bundle.
    always @(negedge clk) begin
        if (!rst && exValid && exReady) begin
            bundle_t got, want;
            got = {exOp, exUseImm, exImm, exRs1Val, exRs2Val, exRd, exRdWr, exPc};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bundle_unexpected: got %h, required no issue", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL bundle: got op=%0d ui=%b imm=%h r1=%h r2=%h rd=%0d wr=%b pc=%h, required op=%0d ui=%b imm=%h r1=%h r2=%h rd=%0d wr=%b pc=%h",
                             got.op, got.use_imm, got.imm, got.r1v, got.r2v, got.rd, got.rd_wr, got.pc,
                             want.op, want.use_imm, want.imm, want.r1v, want.r2v, want.rd, want.rd_wr, want.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] w, input logic [31:0] pc);
        int guard = 0;
        instr = w; instrPc = pc; instrValid = 1'b1;
        while (!instrReady && guard < 50) begin
            tick();
            guard++;
        end
        if (!instrReady) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: instrReady=%b, required 1", instrReady);
        end
        tick();
        instrValid = 1'b0; instr = $urandom(); instrPc = $urandom();
    endtask

    // Register file model: answers with regs[] at the indices the DUT presents.
    task automatic reg_read(input int lat);
        for (int i = 1; i < lat; i++) tick();
        regOutputValid = 1'b1; rs1Dat = regs[rs1]; rs2Dat = regs[rs2];
        tick();
        regOutputValid = 1'b0; rs1Dat = $urandom(); rs2Dat = $urandom();
    endtask

    task automatic wait_issue();
        int guard = 0;
        while (!(exValid && exReady) && guard < 50) begin
            tick();
            guard++;
        end
        if (!(exValid && exReady)) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: exValid=%b exReady=%b, required both 1", exValid, exReady);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({instrReady, regLd, exValid, illegal, exRdWr, exUseImm, dbgState} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b ld=%b v=%b ill=%b wr=%b ui=%b st=%0d, required rdy=1 others 0",
                     instrReady, regLd, exValid, illegal, exRdWr, exUseImm, dbgState);
        end
        n_checks++;
        if ({exOp, exImm, exRs1Val, exRs2Val, exRd, exPc, rs1, rs2} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got op=%0d imm=%h r1=%h r2=%h rd=%0d pc=%h rs1=%0d rs2=%0d, required all 0",
                     exOp, exImm, exRs1Val, exRs2Val, exRd, exPc, rs1, rs2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        regs[1] = 32'd5; regs[2] = 32'd7;
        exp_q.push_back(mk(ADD, 1'b0, 32'h0, 32'd5, 32'd7, 5'd3, 32'h100));
        accept(32'h002081B3, 32'h100);
        n_checks++;
        if ({regLd, rs1, rs2, exValid, instrReady} !== {1'b1, 5'd1, 5'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_regrd: got ld=%b rs1=%0d rs2=%0d v=%b rdy=%b, required ld=1 rs1=1 rs2=2 v=0 rdy=0",
                     regLd, rs1, rs2, exValid, instrReady);
        end
        tick();
        n_checks++;
        if (regLd !== 1'b1) begin
            n_fail++;
            $display("FAIL add_regld_hold: got regLd=%b, required 1", regLd);
        end
        regOutputValid = 1'b1; rs1Dat = regs[rs1]; rs2Dat = regs[rs2];
        tick();
        regOutputValid = 1'b0;
        n_checks++;
        if ({regLd, exValid} !== 2'b01) begin
            n_fail++;
            $display("FAIL add_issue: got regLd=%b exValid=%b, required 0 1", regLd, exValid);
        end
        wait_issue();
        n_checks++;
        if ({exValid, instrReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL add_idle: got exValid=%b instrReady=%b, required 0 1", exValid, instrReady);
        end
    endtask

    task automatic test_sub_srai();
        logic [31:0] pc;
        regs[1] = $urandom(); regs[4] = $urandom();
        pc = $urandom();
        exp_q.push_back(mk(SUB, 1'b0, 32'h0, regs[1], regs[2], 5'd2, pc));
        accept(32'h40208133, pc);
        reg_read(1);
        wait_issue();
        pc = $urandom();
        exp_q.push_back(mk(SRA, 1'b1, 32'h0000_0403, regs[4], 32'h0, 5'd4, pc));
        accept(32'h40325213, pc);
        n_checks++;
        if ({regLd, rs1, rs2} !== {1'b1, 5'd4, 5'd0}) begin
            n_fail++;
            $display("FAIL srai_regrd: got ld=%b rs1=%0d rs2=%0d, required ld=1 rs1=4 rs2=0", regLd, rs1, rs2);
        end
        reg_read(3);
        wait_issue();
    endtask

    task automatic test_addi_x0();
        exp_q.push_back(mk(ADD, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 32'h200));
        accept(32'hFFF00013, 32'h200);
        reg_read(2);
        wait_issue();
    endtask

    task automatic test_lui_auipc();
        exp_q.push_back(mk(PASSB, 1'b1, 32'h1234_5000, 32'h0, 32'h0, 5'd1, 32'h300));
        accept(32'h123450B7, 32'h300);
        n_checks++;
        if ({regLd, exValid} !== 2'b01) begin
            n_fail++;
            $display("FAIL lui_direct: got regLd=%b exValid=%b, required 0 1", regLd, exValid);
        end
        wait_issue();
        n_checks++;
        if (instrReady !== 1'b1) begin
            n_fail++;
            $display("FAIL lui_ready: got instrReady=%b, required 1", instrReady);
        end
        exp_q.push_back(mk(ADD, 1'b1, 32'h0000_1000, 32'h8000_0040, 32'h0, 5'd5, 32'h8000_0040));
        accept(32'h00001297, 32'h8000_0040);
        n_checks++;
        if ({regLd, exValid} !== 2'b01) begin
            n_fail++;
            $display("FAIL auipc_direct: got regLd=%b exValid=%b, required 0 1", regLd, exValid);
        end
        wait_issue();
        exp_q.push_back(mk(ADD, 1'b1, 32'hFFFF_F000, 32'h0000_0ABC, 32'h0, 5'd5, 32'h0000_0ABC));
        accept(32'hFFFFF297, 32'h0000_0ABC);
        wait_issue();
    endtask

    task automatic test_stall();
        logic [31:0] pc;
        pc = $urandom();
        exReady = 1'b0;
        exp_q.push_back(mk(PASSB, 1'b1, 32'hABCD_E000, 32'h0, 32'h0, 5'd2, pc));
        accept(32'hABCDE137, pc);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({exValid, instrReady, exOp, exUseImm, exImm, exRs1Val, exRd, exRdWr, exPc} !==
                {1'b1, 1'b0, PASSB, 1'b1, 32'hABCD_E000, 32'h0, 5'd2, 1'b1, pc}) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got v=%b rdy=%b op=%0d imm=%h r1=%h rd=%0d pc=%h, required v=1 rdy=0 op=%0d imm=abcde000 r1=0 rd=2 pc=%h",
                         i, exValid, instrReady, exOp, exImm, exRs1Val, exRd, exPc, PASSB, pc);
            end
            instr = $urandom(); instrValid = 1'b1; instrPc = $urandom();
            regOutputValid = 1'($urandom_range(0, 1)); rs1Dat = $urandom();
            tick();
        end
        instrValid = 1'b0; regOutputValid = 1'b0;
        exReady = 1'b1;
        wait_issue();
        n_checks++;
        if ({exValid, instrReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_release: got exValid=%b instrReady=%b, required 0 1", exValid, instrReady);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad[3];
        bad[0] = 32'h0000_0000;
        bad[1] = 32'h022081B3;
        bad[2] = 32'h40109093;
        for (int i = 0; i < 3; i++) begin
            accept(bad[i], 32'h400);
            n_checks++;
            if ({illegal, exValid, instrReady, regLd} !== 4'b1010) begin
                n_fail++;
                $display("FAIL illegal_pulse: instr %h got ill=%b v=%b rdy=%b ld=%b, required 1 0 1 0",
                         bad[i], illegal, exValid, instrReady, regLd);
            end
            tick();
            n_checks++;
            if ({illegal, exValid} !== 2'b00) begin
                n_fail++;
                $display("FAIL illegal_clear: instr %h got ill=%b v=%b, required 0 0", bad[i], illegal, exValid);
            end
        end
    endtask

    task automatic test_reset_regrd();
        accept(32'h002081B3, 32'h500);
        n_checks++;
        if (regLd !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got regLd=%b, required 1", regLd);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({regLd, exValid, instrReady} !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_regrd: got ld=%b v=%b rdy=%b, required 0 0 1", regLd, exValid, instrReady);
        end
        regOutputValid = 1'b1; rs1Dat = $urandom(); rs2Dat = $urandom();
        tick();
        regOutputValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({exValid, regLd} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_no_issue: cycle %0d got v=%b ld=%b, required 0 0", i, exValid, regLd);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] imm_f3[6];
        imm_f3[0] = 3'd0; imm_f3[1] = 3'd2; imm_f3[2] = 3'd3;
        imm_f3[3] = 3'd4; imm_f3[4] = 3'd6; imm_f3[5] = 3'd7;
        for (int k = 0; k < 12; k++) begin
            int          kind;
            int          lat;
            logic [4:0]  a, b, d;
            logic [2:0]  f3;
            logic [11:0] im;
            logic [19:0] u;
            logic [31:0] w, pc;
            kind = $urandom_range(0, 2);
            lat  = $urandom_range(1, 3);
            a = 5'($urandom()); b = 5'($urandom()); d = 5'($urandom());
            im = 12'($urandom()); u = 20'($urandom()); pc = $urandom();
            case (kind)
                0: begin
                    f3 = 3'($urandom());
                    w = {7'h00, b, a, f3, d, OPC_OP};
                    exp_q.push_back(mk(ref_op(f3), 1'b0, 32'h0, regs[a], regs[b], d, pc));
                end
                1: begin
                    f3 = imm_f3[$urandom_range(0, 5)];
                    w = {im, a, f3, d, OPC_OPIMM};
                    exp_q.push_back(mk(ref_op(f3), 1'b1, {{20{im[11]}}, im}, regs[a], 32'h0, d, pc));
                end
                default: begin
                    w = {u, d, OPC_LUI};
                    exp_q.push_back(mk(PASSB, 1'b1, {u, 12'b0}, 32'h0, 32'h0, d, pc));
                end
            endcase
            accept(w, pc);
            if (kind != 2) reg_read(lat);
            wait_issue();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom();
        test_reset();
        test_add();
        test_sub_srai();
        test_addi_x0();
        test_lui_auipc();
        test_stall();
        test_illegal();
        test_reset_regrd();
        test_back_to_back();
        tick(); tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: got %0d bundles outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
